jtag_tap_ctrl: RTL
==================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 The module SHALL have parameter IDCODE_VAL, default 32'h1234_5679, which is the value captured by IDCODE; bit 0 SHALL be 1.
REQ-002 The module SHALL have parameter USER_W, default 16, which is the user data register width.
REQ-003 The module SHALL have port tck, input, 1 bit: the only clock; TAP state and shift registers change on posedge, tdo and update registers on negedge.
REQ-004 The module SHALL have port trst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port tms, input, 1 bit: mode select, sampled on posedge tck.
REQ-006 The module SHALL have port tdi, input, 1 bit: serial data in, sampled on posedge tck.
REQ-007 The module SHALL have port tdo, output, 1 bit: serial data out, registered on negedge tck.
REQ-008 The module SHALL have port tdo_en, output, 1 bit: high while tdo carries shift data, registered on negedge tck.
REQ-009 The module SHALL have port tap_state, output, 4 bits: current TAP state encoding.
REQ-010 The module SHALL have port user_in, input, USER_W bits: value captured into the user shift register in Capture-DR.
REQ-011 The module SHALL have port user_out, output, USER_W bits: user update register.
REQ-012 The module SHALL have port user_upd, output, 1 bit: one-tck pulse, high for the tck cycle following the Update-DR negedge, only when the USER instruction is active.

Function
REQ-013 The TAP state machine SHALL implement the 16 IEEE 1149.1 states (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR) with the standard tms-driven transitions on posedge tck.
REQ-014 Five consecutive posedge tck with tms=1 SHALL reach TLR from any state.
REQ-015 The instruction register SHALL be 4 bits, with opcodes IDCODE=4'h1, USER=4'h8, BYPASS=4'hF; any other opcode SHALL select BYPASS.
REQ-016 In CapIR, the IR shift register SHALL load 4'b0101.
REQ-017 In ShIR, each posedge SHALL shift tdi into the MSB and move the LSB toward tdo.
REQ-018 The IR SHALL load the IR shift register on negedge tck while in UpdIR.
REQ-019 In CapDR, the selected DR SHALL load: IDCODE_VAL for IDCODE, user_in for USER, and 0 for BYPASS.
REQ-020 In ShDR, the selected DR SHALL shift LSB-first, with tdi entering the MSB; BYPASS SHALL be a 1-bit register.
REQ-021 On negedge tck in UpdDR with USER active, user_out SHALL load the user shift register; IDCODE and BYPASS updates SHALL have no effect.
REQ-022 On each negedge tck, tdo SHALL take the LSB of the IR shift register in ShIR or of the selected DR shift register in ShDR, with tdo_en=1.
REQ-023 Outside ShIR and ShDR, tdo SHALL be 0 and tdo_en SHALL be 0.
REQ-024 While in TLR, the IR SHALL be forced to IDCODE on every negedge, regardless of tms.
REQ-025 Pause states SHALL hold all shift register contents unchanged.
REQ-026 Shift-register contents in states other than capture or shift SHALL be unchanged.
REQ-027 The user shift register SHALL change only when USER is the active instruction.

Reset
REQ-028 While trst=1, the module SHALL asynchronously force tap_state=TLR, IR=IDCODE, all shift registers=0, user_out=0, user_upd=0, tdo=0, tdo_en=0.
REQ-029 A trst assertion mid-shift SHALL abort the shift with no update of IR or user_out.
REQ-030 After trst release, the first posedge SHALL evaluate transitions from TLR.

Structure
REQ-031 Package jtag_pkg SHALL hold the tap_state_e enum (4-bit, TLR=4'hF, RTI=4'hC, remaining values IEEE-encoded), the opcode localparams, and IR_W=4.
REQ-032 The state machine SHALL be a separate sub-module, jtag_tap_fsm, with ports tck, trst, tms, and state; datapath and tdo logic SHALL remain in jtag_tap_ctrl.

Verification
REQ-033 trst pulse, then tms=0 for one tck -> tap_state goes TLR->RTI; IR=4'h1; tdo_en=0.
REQ-034 From RTI, tms 1,0,0 then 32 ShDR clocks -> tdo bits LSB-first equal 32'h1234_5679; tdo_en=1 only during shift.
REQ-035 Load IR=4'hF, then shift DR with tdi pattern 1,0,1,1 -> tdo shows 0,1,0,1, i.e. a one-cycle delay with leading captured 0.
REQ-036 Load IR=4'h8, shift in 16'hA5C3, pass UpdDR -> user_out=16'hA5C3 and a single user_upd pulse; a second shift with user_in=16'h0F0F -> tdo reads 16'h0F0F.
REQ-037 From PauDR, hold tms=1 for 5 clocks -> tap_state=TLR and IR=4'h1; user_out is unchanged.
REQ-038 Assert trst after 7 of 16 user shift bits -> immediate TLR, user_out is unchanged, user_upd stays 0, tdo=0.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: IEEE state encoding, opcodes and the transition function.
package jtag_pkg;

   localparam int unsigned IR_W = 4;

   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SelDR  = 4'h7,
      CapDR  = 4'h6,
      ShDR   = 4'h2,
      Ex1DR  = 4'h1,
      PauDR  = 4'h3,
      Ex2DR  = 4'h0,
      UpdDR  = 4'h5,
      SelIR  = 4'h4,
      CapIR  = 4'hE,
      ShIR   = 4'hA,
      Ex1IR  = 4'h9,
      PauIR  = 4'hB,
      Ex2IR  = 4'h8,
      UpdIR  = 4'hD
   } tap_state_e;

   localparam logic [IR_W-1:0] OP_IDCODE  = 4'h1;
   localparam logic [IR_W-1:0] OP_USER    = 4'h8;
   localparam logic [IR_W-1:0] OP_BYPASS  = 4'hF;
   localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;

   function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms);
      tap_state_e nxt;
      nxt = TLR;
      case (cur)
         TLR:     nxt = tms ? TLR   : RTI;
         RTI:     nxt = tms ? SelDR : RTI;
         SelDR:   nxt = tms ? SelIR : CapDR;
         CapDR:   nxt = tms ? Ex1DR : ShDR;
         ShDR:    nxt = tms ? Ex1DR : ShDR;
         Ex1DR:   nxt = tms ? UpdDR : PauDR;
         PauDR:   nxt = tms ? Ex2DR : PauDR;
         Ex2DR:   nxt = tms ? UpdDR : ShDR;
         UpdDR:   nxt = tms ? SelDR : RTI;
         SelIR:   nxt = tms ? TLR   : CapIR;
         CapIR:   nxt = tms ? Ex1IR : ShIR;
         ShIR:    nxt = tms ? Ex1IR : ShIR;
         Ex1IR:   nxt = tms ? UpdIR : PauIR;
         PauIR:   nxt = tms ? Ex2IR : PauIR;
         Ex2IR:   nxt = tms ? UpdIR : ShIR;
         UpdIR:   nxt = tms ? SelDR : RTI;
         default: nxt = TLR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state register, advanced on posedge tck.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   output logic [3:0] state
);

   logic [3:0] state_d, state_q;

   always_comb begin
      state_d = tap_next(tap_state_e'(state_q), tms);
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         state_q <= TLR;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP with IDCODE, BYPASS and a USER data register; shifts on posedge,
// drives tdo and applies updates on negedge tck.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
   parameter int unsigned USER_W     = 16
) (
   input  logic              tck,
   input  logic              trst,
   input  logic              tms,
   input  logic              tdi,
   output logic              tdo,
   output logic              tdo_en,
   output logic [3:0]        tap_state,
   input  logic [USER_W-1:0] user_in,
   output logic [USER_W-1:0] user_out,
   output logic              user_upd
);

   logic [3:0] state;

   jtag_tap_fsm u_fsm (
      .tck   (tck),
      .trst  (trst),
      .tms   (tms),
      .state (state)
   );

   assign tap_state = state;

   logic [IR_W-1:0]   ir_d, ir_q;
   logic [IR_W-1:0]   ir_sr_d, ir_sr_q;
   logic [31:0]       id_sr_d, id_sr_q;
   logic              byp_sr_d, byp_sr_q;
   logic [USER_W-1:0] user_sr_d, user_sr_q;
   logic [USER_W-1:0] user_out_d, user_out_q;
   logic              user_upd_d, user_upd_q;
   logic              tdo_d, tdo_q;
   logic              tdo_en_d, tdo_en_q;

   logic sel_idcode, sel_user, dr_lsb;

   // Every opcode other than IDCODE and USER falls through to BYPASS.
   assign sel_idcode = (ir_q == OP_IDCODE);
   assign sel_user   = (ir_q == OP_USER);
   assign dr_lsb     = sel_idcode ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_sr_q);

   always_comb begin
      ir_sr_d   = ir_sr_q;
      id_sr_d   = id_sr_q;
      byp_sr_d  = byp_sr_q;
      user_sr_d = user_sr_q;
      case (tap_state_e'(state))
         CapIR: ir_sr_d = IR_CAPTURE;
         ShIR:  ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
         CapDR: begin
            if (sel_idcode) begin
               id_sr_d = IDCODE_VAL;
            end else if (sel_user) begin
               user_sr_d = user_in;
            end else begin
               byp_sr_d = 1'b0;
            end
         end
         ShDR: begin
            if (sel_idcode) begin
               id_sr_d = {tdi, id_sr_q[31:1]};
            end else if (sel_user) begin
               user_sr_d = {tdi, user_sr_q[USER_W-1:1]};
            end else begin
               byp_sr_d = tdi;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         ir_sr_q   <= '0;
         id_sr_q   <= '0;
         byp_sr_q  <= 1'b0;
         user_sr_q <= '0;
      end else begin
         ir_sr_q   <= ir_sr_d;
         id_sr_q   <= id_sr_d;
         byp_sr_q  <= byp_sr_d;
         user_sr_q <= user_sr_d;
      end
   end

   always_comb begin
      ir_d = ir_q;
      if (state == TLR) begin
         ir_d = OP_IDCODE;
      end else if (state == UpdIR) begin
         ir_d = ir_sr_q;
      end
      user_upd_d = (state == UpdDR) && sel_user;
      user_out_d = user_upd_d ? user_sr_q : user_out_q;
      tdo_en_d   = (state == ShIR) || (state == ShDR);
      tdo_d      = 1'b0;
      if (state == ShIR) begin
         tdo_d = ir_sr_q[0];
      end else if (state == ShDR) begin
         tdo_d = dr_lsb;
      end
   end

   always_ff @(negedge tck or posedge trst) begin
      if (trst) begin
         ir_q       <= OP_IDCODE;
         user_out_q <= '0;
         user_upd_q <= 1'b0;
         tdo_q      <= 1'b0;
         tdo_en_q   <= 1'b0;
      end else begin
         ir_q       <= ir_d;
         user_out_q <= user_out_d;
         user_upd_q <= user_upd_d;
         tdo_q      <= tdo_d;
         tdo_en_q   <= tdo_en_d;
      end
   end

   assign tdo      = tdo_q;
   assign tdo_en   = tdo_en_q;
   assign user_out = user_out_q;
   assign user_upd = user_upd_q;

endmodule
